// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder: group width, group count
// and the generic lookahead carry expression used at both lookahead levels.
package cla_pkg;

   localparam int CLA_GROUP_W = 4;

   // Number of lookahead groups needed to cover n bits, ceil(n/4).
   function automatic int cla_num_groups(input int n);
      return (n + CLA_GROUP_W - 1) / CLA_GROUP_W;
   endfunction

   // Carry out of position i in flattened lookahead form:
   // g_i | p_i g_(i-1) | ... | p_i..p_1 g_0 | p_i..p_0 c0.
   // i = -1 returns c0 unchanged. Callers pass a constant i, so the loops
   // unroll into a two-level AND/OR, with no ripple through earlier carries.
   function automatic logic cla_lookahead(input logic [63:0] p,
                                          input logic [63:0] g,
                                          input logic        c0,
                                          input int          i);
      logic c;
      logic t;
      c = 1'b0;
      for (int j = 0; j <= i; j++) begin
         t = g[j];
         for (int k = j + 1; k <= i; k++) t = t & p[k];
         c = c | t;
      end
      t = c0;
      for (int k = 0; k <= i; k++) t = t & p[k];
      return c | t;
   endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational lookahead group of W (<= 4) bits. Produces the carry into
// each bit of the group plus group generate/propagate for the next level.
module cla_group4
   import cla_pkg::*;
#(
   parameter int W = CLA_GROUP_W
) (
   input  logic [W-1:0] p,
   input  logic [W-1:0] g,
   input  logic         ci,
   output logic [W-1:0] c,
   output logic         gg,
   output logic         gp
);

   // Carry into each bit, every one expanded directly from ci.
   always_comb begin
      c    = '0;
      c[0] = ci;
      for (int i = 1; i < W; i++) begin
         c[i] = cla_lookahead(64'(p), 64'(g), ci, i - 1);
      end
   end

   assign gg = cla_lookahead(64'(p), 64'(g), 1'b0, W - 1);
   assign gp = &p;

endmodule

// File: rtl/cla_adder.sv
// Registered N-bit carry-lookahead adder: {cout, s} = a + b + cin, one-cycle
// latency with a valid qualifier. Two lookahead levels: 4-bit groups, then a
// lookahead across group GG/GP.
// Optional build macro CLA_ADDER_OVF_EN adds the registered two's-complement
// overflow output ovf.
module cla_adder
   import cla_pkg::*;
#(
   parameter int ADDER_SIZE = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDER_SIZE-1:0] a,
   input  logic [ADDER_SIZE-1:0] b,
   input  logic                  cin,
   input  logic                  in_valid,
   output logic [ADDER_SIZE-1:0] s,
   output logic                  cout,
   output logic                  out_valid
`ifdef CLA_ADDER_OVF_EN
   ,
   output logic                  ovf
`endif
);

   localparam int NG = cla_num_groups(ADDER_SIZE);
   localparam int LW = ADDER_SIZE - (NG - 1) * CLA_GROUP_W;

   logic [ADDER_SIZE-1:0] p;
   logic [ADDER_SIZE-1:0] g;
   logic [ADDER_SIZE-1:0] c_bit;
   logic [ADDER_SIZE-1:0] sum_c;
   logic [NG-1:0]         grp_gg;
   logic [NG-1:0]         grp_gp;
   logic [NG:0]           grp_ci;

   logic [ADDER_SIZE-1:0] s_d, s_q;
   logic                  cout_d, cout_q;
   logic                  out_valid_d, out_valid_q;

   assign p = a ^ b;
   assign g = a & b;

   // Second lookahead level: each group carry-in (and the final carry out,
   // grp_ci[NG]) is formed directly from group GG/GP and cin.
   always_comb begin
      grp_ci    = '0;
      grp_ci[0] = cin;
      for (int k = 1; k <= NG; k++) begin
         grp_ci[k] = cla_lookahead(64'(grp_gp), 64'(grp_gg), cin, k - 1);
      end
   end

   for (genvar k = 0; k < NG; k++) begin : g_grp
      localparam int GW = (k == NG - 1) ? LW : CLA_GROUP_W;
      localparam int B  = k * CLA_GROUP_W;

      cla_group4 #(
         .W (GW)
      ) u_grp (
         .p  (p[B +: GW]),
         .g  (g[B +: GW]),
         .ci (grp_ci[k]),
         .c  (c_bit[B +: GW]),
         .gg (grp_gg[k]),
         .gp (grp_gp[k])
      );
   end

   assign sum_c = p ^ c_bit;

   // Capture a new result only on in_valid; otherwise hold it.
   always_comb begin
      s_d         = s_q;
      cout_d      = cout_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         s_d    = sum_c;
         cout_d = grp_ci[NG];
      end
   end

   // Output registers, cleared by asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q         <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         s_q         <= s_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign s         = s_q;
   assign cout      = cout_q;
   assign out_valid = out_valid_q;

`ifdef CLA_ADDER_OVF_EN
   logic ovf_d, ovf_q;

   // Overflow is carry-out versus carry into the sign bit, same update rule.
   always_comb begin
      ovf_d = ovf_q;
      if (in_valid) ovf_d = grp_ci[NG] ^ c_bit[ADDER_SIZE-1];
   end

   // Overflow register, cleared by asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_adder.sv
// Scoreboard bench for cla_adder: five instances (1, 5, 8, 13, 32 bits) share
// one stimulus stream; expected results are queued at issue time and popped
// by a monitor whenever an instance raises out_valid.
`timescale 1ns/1ps
module tb_cla_adder;

   localparam int ND          = 5;
   localparam int WIDTHS [ND] = '{1, 5, 8, 13, 32};
   localparam int IDX8        = 2;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic [31:0] a_v   = '0;
   logic [31:0] b_v   = '0;
   logic        cin_v = 1'b0;
   logic        vld   = 1'b0;

   logic [32:0] res  [ND];
   logic        ov   [ND];
   logic        ovfo [ND];

   logic [33:0] expq [ND][$];
   logic [33:0] e;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < ND; i++) begin : g_dut
      localparam int W = WIDTHS[i];
      logic [W-1:0] s_w;
      logic         co_w;
      logic         ov_w;
`ifdef CLA_ADDER_OVF_EN
      logic         ovf_w;
`endif
      cla_adder #(
         .ADDER_SIZE (W)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .a         (a_v[W-1:0]),
         .b         (b_v[W-1:0]),
         .cin       (cin_v),
         .in_valid  (vld),
         .s         (s_w),
         .cout      (co_w),
         .out_valid (ov_w)
`ifdef CLA_ADDER_OVF_EN
         ,
         .ovf       (ovf_w)
`endif
      );
      assign res[i] = 33'({co_w, s_w});
      assign ov[i]  = ov_w;
`ifdef CLA_ADDER_OVF_EN
      assign ovfo[i] = ovf_w;
`else
      assign ovfo[i] = 1'b0;
`endif
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: {ovf, result} for a w-bit add, overflow from operand/result signs.
   function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                         input logic [31:0] b, input logic c);
      logic [32:0] m, am, bm, r;
      logic        o;
      m  = (33'd1 << w) - 33'd1;
      am = {1'b0, a} & m;
      bm = {1'b0, b} & m;
      r  = am + bm + 33'(c);
      o  = (am[w-1] == bm[w-1]) && (r[w-1] != am[w-1]);
      return {o, r};
   endfunction

   // Drive one valid vector; hexp = {ovf, cout, s} hand value for the 8-bit DUT.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic hand, input logic [9:0] hexp);
      logic [33:0] x;
      a_v = a; b_v = b; cin_v = c; vld = 1'b1;
      for (int i = 0; i < ND; i++) begin
         x = model(WIDTHS[i], a, b, c);
         if (hand && i == IDX8) x = {hexp[9], 24'd0, hexp[8:0]};
         expq[i].push_back(x);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input logic [31:0] a, input logic [31:0] b);
      a_v = a; b_v = b; vld = 1'b0;
      @(posedge clk); #1;
   endtask

   // Monitor: pop and compare whenever an instance presents a result.
   always @(negedge clk) begin
      for (int i = 0; i < ND; i++) begin
         if (ov[i] === 1'b1) begin
            if (expq[i].size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out w%0d actual=%0h required=none", WIDTHS[i], res[i]);
            end else begin
               e = expq[i].pop_front();
               chk($sformatf("sum_w%0d", WIDTHS[i]), 64'(res[i]), 64'(e[32:0]));
`ifdef CLA_ADDER_OVF_EN
               chk($sformatf("ovf_w%0d", WIDTHS[i]), 64'(ovfo[i]), 64'(e[33]));
`endif
            end
         end
      end
   end

   logic [7:0] da [8] = '{8'hAB, 8'h9D, 8'hFF, 8'h7F, 8'hAA, 8'hAA, 8'hFF, 8'h80};
   logic [7:0] db [8] = '{8'hCD, 8'hB2, 8'h00, 8'h01, 8'h55, 8'h55, 8'hFF, 8'h80};
   logic       dc [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic [9:0] dx [8] = '{10'h379, 10'h34F, 10'h100, 10'h280, 10'h0FF, 10'h100, 10'h1FF, 10'h300};

   initial begin
      // Reset state
      #12;
      chk("rst_sum", 64'(res[IDX8]), 64'd0);
      chk("rst_valid", 64'(ov[IDX8]), 64'd0);
`ifdef CLA_ADDER_OVF_EN
      chk("rst_ovf", 64'(ovfo[IDX8]), 64'd0);
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed vectors back to back
      for (int i = 0; i < 8; i++) issue({24'd0, da[i]}, {24'd0, db[i]}, dc[i], 1'b1, dx[i]);

      // Hold: result stays, out_valid drops
      issue(32'h11, 32'h22, 1'b0, 1'b1, 10'h033);
      idle(32'h5A, 32'hC3);
      chk("hold_valid", 64'(ov[IDX8]), 64'd0);
      chk("hold_sum", 64'(res[IDX8]), 64'h033);

      // Asynchronous reset mid-stream, between clock edges
      issue(32'h44, 32'h11, 1'b1, 1'b1, 10'h056);
      #1;
      rst = 1'b1; vld = 1'b0;
      for (int i = 0; i < ND; i++) expq[i].delete();
      #1;
      chk("arst_sum", 64'(res[IDX8]), 64'd0);
      chk("arst_valid", 64'(ov[IDX8]), 64'd0);
      chk("arst_sum_w32", 64'(res[4]), 64'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      issue(32'h3C, 32'h0F, 1'b1, 1'b1, 10'h04C);

      // Pattern vectors across all widths
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 10'h0);
      issue(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 10'h0);
      issue(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 10'h0);
      issue(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 10'h0);
      issue(32'h55555555, 32'h55555555, 1'b1, 1'b0, 10'h0);
      issue(32'h00000000, 32'h00000000, 1'b0, 1'b0, 10'h0);

      // Random vectors with occasional idle cycles
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) idle($urandom, $urandom);
         else issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 10'h0);
      end

      idle(32'h0, 32'h0);
      idle(32'h0, 32'h0);
      idle(32'h0, 32'h0);
      for (int i = 0; i < ND; i++) chk($sformatf("drain_w%0d", WIDTHS[i]), 64'(expq[i].size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
